// File: rtl/line_buf_pkg.sv
// Shared definitions for the line-buffer write controller: controller states,
// page-pointer width helper, pixel-count saturation helper and the statistics
// counter ceiling.
package line_buf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DROP  = 2'd2
    } lb_state_e;

    // Ceiling of the optional 16-bit statistics counters
    localparam logic [15:0] STAT_SAT = 16'hFFFF;

    // Bits needed to index one of 'pages' line pages (pages is a power of 2)
    function automatic int page_w(input int pages);
        return $clog2(pages);
    endfunction

    // Highest pixel index that fits in one page of 2^addr_w pixels
    function automatic int pix_max(input int addr_w);
        return (1 << addr_w) - 1;
    endfunction

endpackage

// File: rtl/line_buf_page_ring.sv
// Page ring for the line buffer: write pointer, last committed page and the
// number of committed pages the reader has not released yet.
module line_buf_page_ring
    import line_buf_pkg::*;
#(
    parameter int  C_PAGES = 4,
    localparam int PW      = page_w(C_PAGES)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          commit_i,
    input  logic          release_i,
    input  logic          flush_i,
    output logic [PW-1:0] wr_page_o,
    output logic [PW-1:0] rd_page_o,
    output logic [PW:0]   used_o,
    output logic          full_o
);

    localparam logic [PW:0] FULL_CNT = (PW+1)'(C_PAGES);

    logic [PW-1:0] wr_page_q, wr_page_d;
    logic [PW-1:0] rd_page_q, rd_page_d;
    logic [PW:0]   used_q, used_d;
    logic          rel_eff;

    // A release with nothing outstanding is meaningless and is dropped
    assign rel_eff = release_i && (used_q != '0);

    // Pointer/occupancy update; flush wins over everything else
    always_comb begin
        wr_page_d = wr_page_q;
        rd_page_d = rd_page_q;
        used_d    = used_q;
        if (flush_i) begin
            wr_page_d = '0;
            rd_page_d = '0;
            used_d    = '0;
        end else begin
            if (commit_i) begin
                rd_page_d = wr_page_q;
                wr_page_d = wr_page_q + 1'b1;
            end
            case ({commit_i, rel_eff})
                2'b10:   used_d = used_q + 1'b1;
                2'b01:   used_d = used_q - 1'b1;
                default: used_d = used_q;
            endcase
        end
    end

    // Ring state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_page_q <= '0;
            rd_page_q <= '0;
            used_q    <= '0;
        end else begin
            wr_page_q <= wr_page_d;
            rd_page_q <= rd_page_d;
            used_q    <= used_d;
        end
    end

    assign wr_page_o = wr_page_q;
    assign rd_page_o = rd_page_q;
    assign used_o    = used_q;
    assign full_o    = (used_q == FULL_CNT);

endmodule

// File: rtl/line_buf_wr_ctrl.sv
// Line-buffer write controller: writes incoming pixels of a line into the
// current DPRAM page, commits the page on a clean end-of-line and drops whole
// lines while every page is still owned by the reader.
// Optional macro LINE_BUF_STATS_EN adds FRAME_LINES / DROP_CNT counters.
module line_buf_wr_ctrl
    import line_buf_pkg::*;
#(
    parameter int  C_ADDR_W   = 9,
    parameter int  C_PAGES    = 4,
    parameter int  C_LINE_LEN = 250,
    localparam int PW         = page_w(C_PAGES)
) (
    input  logic                  CLOCK,
    input  logic                  RESET_N,
    input  logic                  PULSE,
    input  logic                  PIXEL_ERROR,
    input  logic                  LINE_SYNC,
    input  logic                  FRAME_SYNC,
    input  logic                  RD_DONE,
    output logic [PW+C_ADDR_W-1:0] DPRAM_WR_ADDR,
    output logic                  DPRAM_WE,
    output logic [PW-1:0]         DPRAM_RD_PAGE,
    output logic                  LINE_FINISHED,
    output logic                  LINE_LEN_ERR,
    output logic                  OVERFLOW,
`ifdef LINE_BUF_STATS_EN
    output logic [15:0]           FRAME_LINES,
    output logic [15:0]           DROP_CNT,
`endif
    output logic [PW:0]           PAGES_USED
);

    localparam logic [C_ADDR_W-1:0] CNT_MAX   = C_ADDR_W'(pix_max(C_ADDR_W));
    localparam logic [C_ADDR_W:0]   LINE_LEN  = (C_ADDR_W+1)'(C_LINE_LEN);
    localparam logic [PW:0]         USED_LAST = (PW+1)'(C_PAGES-1);

    lb_state_e                 state_q, state_d;
    logic [C_ADDR_W-1:0]       count_q, count_d;
    logic                      sat_q, sat_d;     // pixel CNT_MAX already written
    logic                      bad_q, bad_d;
    logic                      we_q, we_d;
    logic [PW+C_ADDR_W-1:0]    addr_q, addr_d;
    logic                      fin_q, fin_d;
    logic                      lerr_q, lerr_d;
    logic                      ovf_q, ovf_d;

    logic [PW-1:0]             wr_page;
    logic                      full;
    logic                      line_end;
    logic                      line_good;
    logic                      commit;
    logic                      rel_eff;
    logic                      full_after;
    logic [C_ADDR_W:0]         line_len;

    // Pixels received on this line; the saturated flag counts the last slot
    assign line_len   = {1'b0, count_q} + {{C_ADDR_W{1'b0}}, sat_q};
    assign line_end   = LINE_SYNC && !FRAME_SYNC && (state_q != ST_IDLE);
    assign line_good  = (line_len == LINE_LEN) && !bad_q;
    assign commit     = line_end && (state_q == ST_WRITE) && line_good;
    assign rel_eff    = RD_DONE && (PAGES_USED != '0);
    // Occupancy as it will be after this cycle; a commit never happens while full
    assign full_after = commit ? ((PAGES_USED == USED_LAST) && !rel_eff)
                               : (full && !rel_eff);

    line_buf_page_ring #(
        .C_PAGES (C_PAGES)
    ) u_ring (
        .clk       (CLOCK),
        .rst_n     (RESET_N),
        .commit_i  (commit),
        .release_i (RD_DONE),
        .flush_i   (FRAME_SYNC),
        .wr_page_o (wr_page),
        .rd_page_o (DPRAM_RD_PAGE),
        .used_o    (PAGES_USED),
        .full_o    (full)
    );

    // FSM state register
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a frame start always restarts writing (pages are flushed)
    always_comb begin
        state_d = state_q;
        if (FRAME_SYNC) begin
            state_d = ST_WRITE;
        end else if (line_end) begin
            state_d = full_after ? ST_DROP : ST_WRITE;
        end
    end

    // FSM outputs: pixel writes, line verdict pulses and the overflow flag
    always_comb begin
        count_d = count_q;
        sat_d   = sat_q;
        bad_d   = bad_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        fin_d   = 1'b0;
        lerr_d  = 1'b0;
        ovf_d   = ovf_q;
        if (FRAME_SYNC) begin
            count_d = '0;
            sat_d   = 1'b0;
            bad_d   = 1'b0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                ST_WRITE: begin
                    if (LINE_SYNC) begin
                        count_d = '0;
                        sat_d   = 1'b0;
                        bad_d   = 1'b0;
                        fin_d   = line_good;
                        lerr_d  = !line_good;
                    end else if (PULSE) begin
                        if (sat_q) begin
                            bad_d = 1'b1;
                        end else begin
                            we_d   = 1'b1;
                            addr_d = {wr_page, count_q};
                            if (count_q == CNT_MAX) begin
                                sat_d = 1'b1;
                            end else begin
                                count_d = count_q + 1'b1;
                            end
                            if (PIXEL_ERROR) begin
                                bad_d = 1'b1;
                            end
                        end
                    end
                end
                ST_DROP: begin
                    if (LINE_SYNC) begin
                        ovf_d   = 1'b1;
                        count_d = '0;
                        sat_d   = 1'b0;
                        bad_d   = 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Datapath and output registers
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            count_q <= '0;
            sat_q   <= 1'b0;
            bad_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            fin_q   <= 1'b0;
            lerr_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            sat_q   <= sat_d;
            bad_q   <= bad_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            fin_q   <= fin_d;
            lerr_q  <= lerr_d;
            ovf_q   <= ovf_d;
        end
    end

    assign DPRAM_WE      = we_q;
    assign DPRAM_WR_ADDR = addr_q;
    assign LINE_FINISHED = fin_q;
    assign LINE_LEN_ERR  = lerr_q;
    assign OVERFLOW      = ovf_q;

`ifdef LINE_BUF_STATS_EN
    logic [15:0] frame_lines_q;
    logic [15:0] drop_cnt_q;

    // Commits since the last frame start and lines dropped since reset
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            frame_lines_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            if (FRAME_SYNC) begin
                frame_lines_q <= '0;
            end else if (commit && (frame_lines_q != STAT_SAT)) begin
                frame_lines_q <= frame_lines_q + 1'b1;
            end
            if (line_end && (state_q == ST_DROP) && (drop_cnt_q != STAT_SAT)) begin
                drop_cnt_q <= drop_cnt_q + 1'b1;
            end
        end
    end

    assign FRAME_LINES = frame_lines_q;
    assign DROP_CNT    = drop_cnt_q;
`endif

endmodule

// File: tb/tb_line_buf_wr_ctrl.sv
// Bench for line_buf_wr_ctrl: directed line scenarios plus a randomized run,
// all predicted by a line-level model of page ownership.
module tb_line_buf_wr_ctrl;

    localparam int ADDR_W = 9;
    localparam int PAGES  = 4;
    localparam int LEN    = 250;
    localparam int PMAX   = 1 << ADDR_W;

    logic        CLOCK;
    logic        RESET_N;
    logic        PULSE;
    logic        PIXEL_ERROR;
    logic        LINE_SYNC;
    logic        FRAME_SYNC;
    logic        RD_DONE;
    logic [10:0] DPRAM_WR_ADDR;
    logic        DPRAM_WE;
    logic [1:0]  DPRAM_RD_PAGE;
    logic        LINE_FINISHED;
    logic        LINE_LEN_ERR;
    logic        OVERFLOW;
    logic [2:0]  PAGES_USED;
`ifdef LINE_BUF_STATS_EN
    logic [15:0] FRAME_LINES;
    logic [15:0] DROP_CNT;
`endif

    line_buf_wr_ctrl #(
        .C_ADDR_W   (ADDR_W),
        .C_PAGES    (PAGES),
        .C_LINE_LEN (LEN)
    ) dut (
        .CLOCK         (CLOCK),
        .RESET_N       (RESET_N),
        .PULSE         (PULSE),
        .PIXEL_ERROR   (PIXEL_ERROR),
        .LINE_SYNC     (LINE_SYNC),
        .FRAME_SYNC    (FRAME_SYNC),
        .RD_DONE       (RD_DONE),
        .DPRAM_WR_ADDR (DPRAM_WR_ADDR),
        .DPRAM_WE      (DPRAM_WE),
        .DPRAM_RD_PAGE (DPRAM_RD_PAGE),
        .LINE_FINISHED (LINE_FINISHED),
        .LINE_LEN_ERR  (LINE_LEN_ERR),
        .OVERFLOW      (OVERFLOW),
`ifdef LINE_BUF_STATS_EN
        .FRAME_LINES   (FRAME_LINES),
        .DROP_CNT      (DROP_CNT),
`endif
        .PAGES_USED    (PAGES_USED)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    int errors = 0;
    int checks = 0;

    // Observed write/pulse activity, sampled on the falling edge
    logic [10:0] wq[$];
    int fin_cnt;
    int lerr_cnt;

    always @(negedge CLOCK) begin
        if (RESET_N) begin
            if (DPRAM_WE) wq.push_back(DPRAM_WR_ADDR);
            if (LINE_FINISHED) fin_cnt++;
            if (LINE_LEN_ERR) lerr_cnt++;
        end
    end

    // Line-level reference model
    bit m_active;    // a frame has started since reset
    bit m_dropping;  // the line in progress will be discarded
    int m_used;
    int m_wr;
    int m_rd;
    bit m_ovf;

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_obs();
        wq.delete();
        fin_cnt  = 0;
        lerr_cnt = 0;
    endtask

    task automatic model_flush();
        m_active   = 1'b1;
        m_dropping = 1'b0;
        m_used     = 0;
        m_wr       = 0;
        m_rd       = 0;
        m_ovf      = 1'b0;
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            PULSE = 1'b1;
            tick();
            PULSE = 1'b0;
        end
    endtask

    task automatic frame_sync(input bit with_ls);
        FRAME_SYNC = 1'b1;
        LINE_SYNC  = with_ls;
        tick();
        FRAME_SYNC = 1'b0;
        LINE_SYNC  = 1'b0;
        model_flush();
    endtask

    task automatic rd_release(input string name);
        RD_DONE = 1'b1;
        tick();
        RD_DONE = 1'b0;
        if (m_used > 0) m_used--;
        check({name, "_used"}, 32'(PAGES_USED), 32'(m_used));
        $display("release %s: used=%0d", name, PAGES_USED);
    endtask

    // One full line: npix pulses, optional error pixel, optional release
    // mid-line (rel_at) or on the LINE_SYNC cycle (rel_sync), then verdict.
    task automatic send_line(input int npix, input int err_idx, input int rel_at,
                             input bit rel_sync, input bit gaps, input string name);
        int exp_n;
        int exp_page;
        int bad;
        bit writing;
        bit good;
        bit rel_eff;
        clear_obs();
        writing  = m_active && !m_dropping;
        exp_page = m_wr;
        exp_n    = writing ? ((npix > PMAX) ? PMAX : npix) : 0;
        for (int i = 0; i < npix; i++) begin
            PULSE       = 1'b1;
            PIXEL_ERROR = (i == err_idx);
            RD_DONE     = (i == rel_at);
            if (i == rel_at && m_used > 0) m_used--;
            tick();
            PULSE       = 1'b0;
            PIXEL_ERROR = 1'b0;
            RD_DONE     = 1'b0;
            if (gaps) repeat ($urandom_range(0, 2)) tick();
        end
        LINE_SYNC = 1'b1;
        RD_DONE   = rel_sync;
        tick();
        LINE_SYNC = 1'b0;
        RD_DONE   = 1'b0;

        good    = writing && (npix == LEN) && !(err_idx >= 0 && err_idx < npix);
        rel_eff = rel_sync && (m_used > 0);
        if (good) begin
            m_rd = m_wr;
            m_wr = (m_wr + 1) % PAGES;
        end
        m_used = m_used + int'(good) - int'(rel_eff);
        if (m_active) begin
            if (m_dropping) m_ovf = 1'b1;
            m_dropping = (m_used == PAGES);
        end
        repeat (2) tick();

        bad = 0;
        for (int i = 0; i < wq.size() && i < exp_n; i++)
            if (wq[i] !== 11'(exp_page * PMAX + i)) bad++;
        check({name, "_nwrites"}, 32'(wq.size()), 32'(exp_n));
        check({name, "_badaddr"}, 32'(bad), 32'd0);
        if (exp_n > 0 && wq.size() > 0) begin
            check({name, "_first"}, 32'(wq[0]), 32'(exp_page * PMAX));
            check({name, "_last"}, 32'(wq[wq.size()-1]), 32'(exp_page * PMAX + exp_n - 1));
        end
        check({name, "_fin"}, 32'(fin_cnt), 32'(good));
        check({name, "_lerr"}, 32'(lerr_cnt), 32'(writing && !good));
        check({name, "_rdpage"}, 32'(DPRAM_RD_PAGE), 32'(m_rd));
        check({name, "_used"}, 32'(PAGES_USED), 32'(m_used));
        check({name, "_ovf"}, 32'(OVERFLOW), 32'(m_ovf));
        check({name, "_we_idle"}, 32'(DPRAM_WE), 32'd0);
        $display("line %s: pix=%0d writes=%0d fin=%0d lerr=%0d rdpage=%0d used=%0d ovf=%0d",
                 name, npix, wq.size(), fin_cnt, lerr_cnt, DPRAM_RD_PAGE, PAGES_USED, OVERFLOW);
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_we"}, 32'(DPRAM_WE), 32'd0);
        check({name, "_addr"}, 32'(DPRAM_WR_ADDR), 32'd0);
        check({name, "_rdpage"}, 32'(DPRAM_RD_PAGE), 32'd0);
        check({name, "_fin"}, 32'(LINE_FINISHED), 32'd0);
        check({name, "_lerr"}, 32'(LINE_LEN_ERR), 32'd0);
        check({name, "_ovf"}, 32'(OVERFLOW), 32'd0);
        check({name, "_used"}, 32'(PAGES_USED), 32'd0);
    endtask

    initial begin
        int kind;
        int len;
        int err;
        int rel;
        bit rsync;

        RESET_N     = 1'b0;
        PULSE       = 1'b0;
        PIXEL_ERROR = 1'b0;
        LINE_SYNC   = 1'b0;
        FRAME_SYNC  = 1'b0;
        RD_DONE     = 1'b0;
        clear_obs();
        model_flush();
        m_active = 1'b0;

        // Reset state
        repeat (3) tick();
        check_outputs_zero("reset");
        RESET_N = 1'b1;
        tick();

        // Idle: nothing is written before the first frame start
        send_line(20, -1, -1, 1'b0, 1'b0, "idle");

        // Pixel error on pixel 17, then a clean line reuses page 0
        frame_sync(1'b0);
        send_line(LEN, 17, -1, 1'b0, 1'b1, "pix_err");
        send_line(LEN, -1, -1, 1'b0, 1'b1, "clean0");
        send_line(LEN - 1, -1, -1, 1'b0, 1'b1, "short");
        send_line(LEN + 1, -1, -1, 1'b0, 1'b1, "long");

        // Fill every page, then overflow with a release mid-line
        send_line(LEN, -1, -1, 1'b0, 1'b1, "fill1");
        send_line(LEN, -1, -1, 1'b0, 1'b1, "fill2");
        send_line(LEN, -1, -1, 1'b0, 1'b1, "fill3");
        send_line(LEN, -1, 120, 1'b0, 1'b1, "drop_rel");
        send_line(LEN, -1, -1, 1'b0, 1'b1, "after_drop");

        // Commit together with a release at two pages in use
        rd_release("rel_a");
        rd_release("rel_b");
        send_line(LEN, -1, -1, 1'b1, 1'b1, "commit_rel");

        // Frame start coinciding with end-of-line
        clear_obs();
        pulses(50);
        frame_sync(1'b1);
        repeat (2) tick();
        check("fsls_fin", 32'(fin_cnt), 32'd0);
        check("fsls_lerr", 32'(lerr_cnt), 32'd0);
        check("fsls_used", 32'(PAGES_USED), 32'd0);
        check("fsls_ovf", 32'(OVERFLOW), 32'd0);
        $display("frame_sync+line_sync: fin=%0d lerr=%0d used=%0d", fin_cnt, lerr_cnt, PAGES_USED);
        rd_release("rel_at_zero");
        send_line(LEN, -1, -1, 1'b0, 1'b1, "post_flush");

        // Address saturation
        frame_sync(1'b0);
        send_line(600, -1, -1, 1'b0, 1'b0, "sat");

        // Randomized lines against the model
        frame_sync(1'b0);
        for (int n = 0; n < 12; n++) begin
            kind  = int'($urandom_range(0, 3));
            len   = LEN;
            err   = -1;
            rel   = -1;
            rsync = ($urandom_range(0, 3) == 0);
            case (kind)
                1: err = int'($urandom_range(0, LEN - 1));
                2: len = ($urandom_range(0, 1) == 1) ? LEN + int'($urandom_range(1, 3))
                                                      : LEN - int'($urandom_range(1, 3));
                3: rel = int'($urandom_range(0, LEN - 1));
                default: ;
            endcase
            send_line(len, err, rel, rsync, 1'b1, $sformatf("rand%0d", n));
        end

        // Reset in the middle of a line
        frame_sync(1'b0);
        send_line(LEN, -1, -1, 1'b0, 1'b0, "pre_rst0");
        send_line(LEN, -1, -1, 1'b0, 1'b0, "pre_rst1");
        clear_obs();
        pulses(100);
        check("midline_we", 32'(DPRAM_WE), 32'd1);
        #2;
        RESET_N = 1'b0;
        #1;
        check_outputs_zero("async_rst");
        clear_obs();
        model_flush();
        m_active = 1'b0;
        PULSE = 1'b1;
        repeat (3) tick();
        PULSE   = 1'b0;
        RESET_N = 1'b1;
        send_line(30, -1, -1, 1'b0, 1'b0, "post_rst_idle");
        frame_sync(1'b0);
        send_line(LEN, -1, -1, 1'b0, 1'b1, "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
